// File: rtl/pcs_rx_ctrl_pkg.sv
// pcs_rx_ctrl_pkg: shared state encoding and resync counter width for the PCS receive link controller
package pcs_rx_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT_SERDES = 3'd1,
    WAIT_BLOCK  = 3'd2,
    WAIT_AM     = 3'd3,
    WAIT_DESKEW = 3'd4,
    LINK_UP     = 3'd5,
    RESYNC      = 3'd6
  } state_t;
  localparam int RESYNC_CNT_W = 8;
  localparam logic [RESYNC_CNT_W-1:0] RESYNC_CNT_MAX = '1;
endpackage

// File: rtl/ber_mon_rx.sv
// ber_mon_rx: windowed invalid-sync-header counter; hi_ber sticks until a window closes below threshold
module ber_mon_rx #(
  parameter int LANE_N      = 4,
  parameter int BER_WIN_CYC = 195313,
  parameter int BER_THRESH  = 97
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [LANE_N-1:0] head_v,
  input  logic [LANE_N-1:0] head_err,
  output logic              hi_ber
);
  localparam int WW = BER_WIN_CYC > 1 ? $clog2(BER_WIN_CYC) : 1;
  localparam int EW = $clog2(BER_THRESH + 1);
  localparam int SW = EW + $clog2(LANE_N + 1);
  logic [WW-1:0] win;
  logic [EW-1:0] err, err_sat;
  logic [SW-1:0] sum;
  logic wrap, hit;
  always_comb begin
    sum = SW'(err);
    for (int i = 0; i < LANE_N; i++) sum = sum + SW'(head_v[i] & head_err[i]);
    err_sat = sum >= SW'(BER_THRESH) ? EW'(BER_THRESH) : EW'(sum);
    hit = err_sat == EW'(BER_THRESH);
    wrap = win == WW'(BER_WIN_CYC - 1);
  end
  // errors on the wrap cycle still count toward the closing window via err_sat
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      win <= '0;
      err <= '0;
      hi_ber <= 1'b0;
    end else begin
      win <= en && !wrap ? win + 1'b1 : '0;
      err <= en && !wrap ? err_sat : '0;
      hi_ber <= en && ((hi_ber && !wrap) || hit);
    end
endmodule

// File: rtl/pcs_rx_link_ctrl.sv
// pcs_rx_link_ctrl: receive link bring-up FSM sequencing serdes, block, AM and deskew lock,
// with timeout-driven resync and BER masking of link_up_o
module pcs_rx_link_ctrl
  import pcs_rx_ctrl_pkg::*;
#(
  parameter int LANE_N      = 4,
  parameter int IS_10G      = 0,
  parameter int TIMEOUT_CYC = 65535,
  parameter int RESYNC_CYC  = 4,
  parameter int BER_WIN_CYC = 195313,
  parameter int BER_THRESH  = 97
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LANE_N-1:0]       serdes_lock_v_i,
  input  logic [LANE_N-1:0]       bs_lock_v_i,
  input  logic [LANE_N-1:0]       am_lock_v_i,
  input  logic                    deskew_v_i,
  input  logic [LANE_N-1:0]       head_v_i,
  input  logic [LANE_N-1:0]       head_err_v_i,
  output logic [LANE_N-1:0]       lane_rst_o,
  output logic                    deskew_rst_o,
  output logic                    link_up_o,
  output logic                    hi_ber_o,
  output logic [2:0]              state_o,
  output logic [RESYNC_CNT_W-1:0] resync_cnt_o
);
  localparam int CYC_MAX = TIMEOUT_CYC > RESYNC_CYC ? TIMEOUT_CYC : RESYNC_CYC;
  localparam int CW = $clog2(CYC_MAX + 1);
  state_t state, nxt;
  logic [CW-1:0] cyc;
  logic s_ok, b_ok, a_ok, lost, tmo, hi_ber;
  always_comb begin
    nxt = state;
    s_ok = &serdes_lock_v_i;
    b_ok = &bs_lock_v_i;
    a_ok = &am_lock_v_i || IS_10G != 0;
    lost = (state inside {WAIT_BLOCK, WAIT_AM, WAIT_DESKEW, LINK_UP} && !s_ok)
        || (state inside {WAIT_AM, WAIT_DESKEW, LINK_UP} && !b_ok)
        || (state inside {WAIT_DESKEW, LINK_UP} && !a_ok);
    tmo = state inside {WAIT_BLOCK, WAIT_AM, WAIT_DESKEW} && cyc == CW'(TIMEOUT_CYC - 1);
    case (state)
      IDLE:        nxt = WAIT_SERDES;
      WAIT_SERDES: nxt = s_ok ? WAIT_BLOCK : WAIT_SERDES;
      WAIT_BLOCK:  nxt = b_ok ? (IS_10G != 0 ? LINK_UP : WAIT_AM) : WAIT_BLOCK;
      WAIT_AM:     nxt = a_ok ? WAIT_DESKEW : WAIT_AM;
      WAIT_DESKEW: nxt = deskew_v_i ? LINK_UP : WAIT_DESKEW;
      LINK_UP:     nxt = LINK_UP;
      RESYNC:      nxt = cyc == CW'(RESYNC_CYC - 1) ? WAIT_SERDES : RESYNC;
      default:     nxt = IDLE;
    endcase
    if (lost || tmo) nxt = RESYNC;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cyc <= '0;
      resync_cnt_o <= '0;
    end else begin
      state <= nxt;
      cyc <= (nxt != state || !(state inside {WAIT_BLOCK, WAIT_AM, WAIT_DESKEW, RESYNC})) ? '0 : cyc + 1'b1;
      if (nxt == RESYNC && state != RESYNC && resync_cnt_o != RESYNC_CNT_MAX)
        resync_cnt_o <= resync_cnt_o + 1'b1;
    end
  assign lane_rst_o = {LANE_N{state == IDLE || state == RESYNC}};
  assign deskew_rst_o = !(state == WAIT_DESKEW || state == LINK_UP);
  assign link_up_o = state == LINK_UP && !hi_ber;
  assign hi_ber_o = hi_ber;
  assign state_o = state;
  ber_mon_rx #(
    .LANE_N(LANE_N),
    .BER_WIN_CYC(BER_WIN_CYC),
    .BER_THRESH(BER_THRESH)
  ) u_ber (
    .clk(clk),
    .reset(reset),
    .en(b_ok),
    .head_v(head_v_i),
    .head_err(head_err_v_i),
    .hi_ber(hi_ber)
  );
endmodule
